control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Multi-cycle sequencer for the control unit. Fetches an instruction over a
//  valid/request handshake into its instruction register, drives the
//  combinational decoders with {ir, state}, and forwards their 29-bit control
//  word to the datapath. Stalls on data-RAM wait, retires on nextState==0, and
//  latches a fault if an instruction never retires.
// PARAMETERS
//  MAX_STEPS  4      EXEC cycles allowed per instruction, RAM-wait cycles excluded
//  MEM_DSEL   2'b10  Dsel code meaning "RAM drives data bus"
// PORTS
//  clock         in   1   system clock, rising edge
//  reset         in   1   asynchronous, active-low reset
//  instr_valid   in   1   instruction memory has instruction[] ready
//  instruction   in   32  fetched instruction
//  decode_cw     in   29  control word from decoders for {ir, state}
//  decode_ns     in   2   nextState from decoders for {ir, state}
//  mem_ready     in   1   data RAM completes the access this cycle
//  fetch_req     out  1   requesting an instruction
//  ir            out  32  instruction register, to decoders
//  state         out  2   micro-state, to decoders
//  control_word  out  29  control word to datapath
//  retire        out  1   one-cycle pulse: instruction completed
//  fault         out  1   sticky: step limit exceeded
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Control word fields [28:0]: Psel[28:27] DA[26:22] SA[21:17] SB[16:12]
//   Fsel[11:7] regW[6] ramW[5] Dsel[4:3] Bsel[2] PCsel[1] SL[0].
//  NOP word = decode_cw with Psel=00, regW=0, ramW=0, SL=0; others pass through.
//  Reset (async): FSM=FETCH, ir=0, state=0, step=0, retire=0, fault=0.
//   control_word is NOP immediately. Reset mid-instruction aborts it, no retire.
//  FSM FETCH: fetch_req=1, control_word=NOP.
//   instr_valid=1 at edge: ir<=instruction, state<=0, step<=0, ->EXEC.
//   instr_valid ignored outside FETCH. Instruction enters EXEC one cycle after accept.
//  FSM EXEC: fetch_req=0. mem_op = ramW | (Dsel==MEM_DSEL).
//   mem_op & !mem_ready: control_word=NOP, hold state, step unchanged (wait).
//   Otherwise control_word=decode_cw (full) and at edge:
//    decode_ns==0: retire<=1 for next cycle, ->FETCH, state<=0.
//    decode_ns!=0: state<=decode_ns, step<=step+1, stay EXEC.
//    step+1==MAX_STEPS with decode_ns!=0: fault<=1, ->HALT.
//  FSM HALT: control_word=NOP, fetch_req=0, retire=0; exits only on reset.
//  Retire then new fetch: retire pulse coincides with the first FETCH cycle;
//   back-to-back instructions cost 1 FETCH + N EXEC cycles minimum.
//  step counter width clog2(MAX_STEPS)+1; never wraps (HALT first).
//  mem_ready sampled only in EXEC with mem_op=1; ignored elsewhere.
//  decode_ns may repeat the same state (loop); counted as a step.
// TESTING
//  1 reset low mid-EXEC with ramW=1 -> control_word[5]=0 same cycle, FSM FETCH,
//    fetch_req=1, ir=0, retire never pulses.
//  2 ADDI (0x91000421), decoder ns=0 -> one EXEC cycle, control_word==decode_cw,
//    retire=1 next cycle, fetch_req=1; cycle count accept->retire = 2.
//  3 load: decode_cw Dsel=10, mem_ready low 3 cycles -> control_word Psel=00,
//    regW=0 for 3 cycles, state held; full word on 4th; retire next.
//  4 decoder ns sequence 1,2,0 -> state 0,1,2 on consecutive EXEC cycles,
//    single retire pulse, fault=0.
//  5 decoder ns stuck at 1, MAX_STEPS=4 -> fault=1 after 4th EXEC edge, HALT,
//    control_word NOP, instr_valid pulses ignored until reset.
//  6 instr_valid high during EXEC with new instruction -> ir unchanged until
//    after retire; captured only in FETCH.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Instruction-fetch, decoder and datapath-control signals of the control sequencer.
interface control_sequencer_if;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [28:0] decode_cw;
    logic [1:0]  decode_ns;
    logic        mem_ready;
    logic        fetch_req;
    logic [31:0] ir;
    logic [1:0]  state;
    logic [28:0] control_word;
    logic        retire;
    logic        fault;

    modport master (
        input  instr_valid, instruction, decode_cw, decode_ns, mem_ready,
        output fetch_req, ir, state, control_word, retire, fault
    );

    modport slave (
        output instr_valid, instruction, decode_cw, decode_ns, mem_ready,
        input  fetch_req, ir, state, control_word, retire, fault
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetches into ir, steps {ir, state} through the
// external decoders, stalls on data-RAM wait and latches a fault on runaway sequences.
module control_sequencer #(
    parameter int unsigned MAX_STEPS = 4,
    parameter logic [1:0]  MEM_DSEL  = 2'b10
) (
    input logic                 clock,
    input logic                 reset,
    control_sequencer_if.master bus
);
    localparam int unsigned STEP_W = $clog2(MAX_STEPS) + 1;
    localparam int unsigned CW_W   = 29;
    localparam int unsigned IR_W   = 32;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } fsm_t;

    fsm_t              r_fsm;
    logic [IR_W-1:0]   r_ir;
    logic [1:0]        r_state;
    logic [STEP_W-1:0] r_step;
    logic              r_retire;
    logic              r_fault;
    logic              r_fetch_req;

    logic              w_mem_op;
    logic              w_wait;
    logic              w_last_step;
    logic [CW_W-1:0]   w_nop;
    logic [CW_W-1:0]   w_cw;

    assign w_mem_op    = bus.decode_cw[5] | (bus.decode_cw[4:3] == MEM_DSEL);
    assign w_wait      = w_mem_op & ~bus.mem_ready;
    assign w_last_step = (r_step + STEP_W'(1)) == STEP_W'(MAX_STEPS);

    // NOP keeps the operand/select fields but kills Psel, regW, ramW and SL.
    assign w_nop = {2'b00, bus.decode_cw[26:7], 1'b0, 1'b0, bus.decode_cw[4:1], 1'b0};

    always_comb begin
        w_cw = w_nop;
        if (r_fsm == S_EXEC && !w_wait) begin
            w_cw = bus.decode_cw;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fsm       <= S_FETCH;
            r_ir        <= '0;
            r_state     <= '0;
            r_step      <= '0;
            r_retire    <= 1'b0;
            r_fault     <= 1'b0;
            r_fetch_req <= 1'b1;
        end else begin
            r_retire <= 1'b0;
            case (r_fsm)
                S_FETCH: begin
                    if (bus.instr_valid) begin
                        r_ir        <= bus.instruction;
                        r_state     <= '0;
                        r_step      <= '0;
                        r_fsm       <= S_EXEC;
                        r_fetch_req <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (!w_wait) begin
                        if (bus.decode_ns == 2'd0) begin
                            r_retire    <= 1'b1;
                            r_state     <= '0;
                            r_fsm       <= S_FETCH;
                            r_fetch_req <= 1'b1;
                        end else begin
                            r_state <= bus.decode_ns;
                            r_step  <= r_step + STEP_W'(1);
                            // Runaway sequence: park until reset.
                            if (w_last_step) begin
                                r_fault <= 1'b1;
                                r_fsm   <= S_HALT;
                            end
                        end
                    end
                end
                S_HALT: begin
                    r_fsm <= S_HALT;
                end
                default: begin
                    r_fsm       <= S_FETCH;
                    r_fetch_req <= 1'b1;
                end
            endcase
        end
    end

    assign bus.fetch_req    = r_fetch_req;
    assign bus.ir           = r_ir;
    assign bus.state        = r_state;
    assign bus.control_word = w_cw;
    assign bus.retire       = r_retire;
    assign bus.fault        = r_fault;
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: behavioural model compared every cycle
// plus hand-computed literal checks for the directed scenarios.
module tb_control_sequencer;
    localparam int MAX_STEPS = 4;
    localparam logic [28:0] KILL_MASK = 29'h1800_0061;

    logic clock = 1'b0;
    logic reset = 1'b0;
    control_sequencer_if bus ();

    control_sequencer #(.MAX_STEPS(MAX_STEPS), .MEM_DSEL(2'b10)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Stand-in decoders: table-driven next state, control word tagged with the state.
    logic [1:0]  dec_ns [4];
    logic [28:0] dec_cw;
    always_comb begin
        bus.decode_ns = dec_ns[bus.state];
        bus.decode_cw = dec_cw ^ (29'(bus.state) << 7);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic needs_ram(input logic [28:0] w);
        return ((w & 29'h20) != 0) || (((w >> 3) & 29'h3) == 29'h2);
    endfunction

    // Behavioural model: 0 = waiting for an instruction, 1 = running, 2 = halted.
    int          m_mode;
    logic [31:0] m_ir;
    logic [1:0]  m_st;
    int          m_steps;
    logic        m_ret;
    logic        m_fault;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_mode <= 0; m_ir <= '0; m_st <= '0; m_steps <= 0; m_ret <= 1'b0; m_fault <= 1'b0;
        end else begin
            m_ret <= 1'b0;
            if (m_mode == 0 && bus.instr_valid) begin
                m_ir <= bus.instruction; m_st <= '0; m_steps <= 0; m_mode <= 1;
            end else if (m_mode == 1 && !(needs_ram(bus.decode_cw) && !bus.mem_ready)) begin
                if (bus.decode_ns == 2'd0) begin
                    m_ret <= 1'b1; m_mode <= 0; m_st <= '0;
                end else begin
                    m_st <= bus.decode_ns;
                    m_steps <= m_steps + 1;
                    if (m_steps + 1 >= MAX_STEPS) begin
                        m_fault <= 1'b1; m_mode <= 2;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            logic run;
            run = (m_mode == 1) && !(needs_ram(bus.decode_cw) && !bus.mem_ready);
            check("cmp.control_word", bus.control_word, run ? bus.decode_cw : (bus.decode_cw & ~KILL_MASK));
            check("cmp.fetch_req", bus.fetch_req, m_mode == 0);
            check("cmp.ir", bus.ir, m_ir);
            check("cmp.state", bus.state, m_st);
            check("cmp.retire", bus.retire, m_ret);
            check("cmp.fault", bus.fault, m_fault);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic issue(input logic [31:0] instr);
        bus.instruction = instr;
        bus.instr_valid = 1'b1;
        cyc();
        bus.instr_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        cyc(2);
        #2 reset = 1'b1;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [28:0] kill;
        bus.instr_valid = 1'b0;
        bus.instruction = '0;
        bus.mem_ready   = 1'b1;
        for (int i = 0; i < 4; i++) dec_ns[i] = 2'd0;
        dec_cw = '0;
        cyc(2);
        chk_en = 1'b1;
        check("reset.fetch_req", bus.fetch_req, 1);
        check("reset.ir", bus.ir, 0);
        check("reset.retire_fault", {bus.retire, bus.fault}, 0);
        #2 reset = 1'b1;
        cyc();

        // NOP of an all-ones word
        dec_cw = 29'h1FFF_FFFF;
        #1 check("nop.literal", bus.control_word, 29'h07FF_FF9E);

        // ADDI, single EXEC cycle
        dec_cw = 29'h0ABC_DEF5;
        issue(32'h9100_0421);
        cnt = 1;
        check("addi.ir", bus.ir, 32'h9100_0421);
        check("addi.cw", bus.control_word, 29'h0ABC_DEF5);
        while (!bus.retire && cnt < 20) begin
            cyc();
            cnt++;
        end
        check("addi.latency", cnt, 2);
        check("addi.fetch_req", bus.fetch_req, 1);

        // Load stalled on RAM for three cycles
        dec_cw = 29'h1000_0050;
        bus.mem_ready = 1'b0;
        issue(32'h8C22_0004);
        for (int i = 0; i < 3; i++) begin
            check("load.wait_cw", bus.control_word, 29'h0000_0010);
            check("load.wait_state", bus.state, 0);
            cyc();
        end
        bus.mem_ready = 1'b1;
        #1 check("load.full_cw", bus.control_word, 29'h1000_0050);
        cyc();
        check("load.retire", bus.retire, 1);

        // Three-state sequence 0 -> 1 -> 2 -> retire
        dec_cw = 29'h0000_0800;
        dec_ns[0] = 2'd1; dec_ns[1] = 2'd2; dec_ns[2] = 2'd0;
        issue(32'h0123_4567);
        for (int i = 0; i < 3; i++) begin
            check("seq.state", bus.state, i);
            check("seq.no_retire", bus.retire, 0);
            cyc();
        end
        check("seq.retire", bus.retire, 1);
        check("seq.fault", bus.fault, 0);
        cyc();
        check("seq.single_pulse", bus.retire, 0);

        // instr_valid during EXEC is ignored; captured once back in FETCH
        dec_ns[0] = 2'd1; dec_ns[1] = 2'd0;
        issue(32'hAAAA_0001);
        bus.instruction = 32'hBBBB_0002;
        bus.instr_valid = 1'b1;
        cyc();
        check("ivalid.exec_hold", bus.ir, 32'hAAAA_0001);
        cyc();
        check("ivalid.retire_hold", bus.ir, 32'hAAAA_0001);
        check("ivalid.retire", bus.retire, 1);
        cyc();
        bus.instr_valid = 1'b0;
        check("ivalid.capture", bus.ir, 32'hBBBB_0002);
        cyc(2);

        // Runaway: next state stuck at 1
        dec_ns[0] = 2'd1; dec_ns[1] = 2'd1;
        dec_cw = 29'h0000_1000;
        issue(32'hDEAD_BEEF);
        cyc(3);
        check("halt.before", bus.fault, 0);
        cyc();
        check("halt.fault", bus.fault, 1);
        check("halt.fetch_req", bus.fetch_req, 0);
        issue(32'h1111_2222);
        cyc(2);
        check("halt.ir_kept", bus.ir, 32'hDEAD_BEEF);
        kill = bus.control_word & KILL_MASK;
        check("halt.cw_nop", kill, 0);
        check("halt.sticky", bus.fault, 1);
        do_reset();
        check("halt.cleared", bus.fault, 0);

        // Reset mid-EXEC with a RAM write in flight
        dec_cw = 29'h1800_0060;
        issue(32'h5555_6666);
        check("rst.cw_before", bus.control_word, 29'h1800_0060);
        #3 reset = 1'b0;
        #1;
        check("rst.ramw_killed", bus.control_word[5], 0);
        check("rst.fetch_req", bus.fetch_req, 1);
        check("rst.ir", bus.ir, 0);
        #3 reset = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            check("rst.no_retire", bus.retire, 0);
            cyc();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
